// File: rtl/ivb_vector_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ivb_vector_fifo                                              |
// | Description : FWFT circular buffer for 256-bit vectors from the vector     |
// |               assembler. Reports occupancy, almost-full and a sticky       |
// |               overflow flag with a saturating drop counter.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ivb_vector_fifo #(
   parameter int DEPTH        = 8,
   parameter int AW           = 3,
   parameter int AFULL_THRESH = 6
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   input  logic [255:0]  in_data,
   output logic          out_valid,
   output logic [255:0]  out_data,
   input  logic          out_ready,
   output logic [AW:0]   count,
   output logic          almost_full,
   output logic          overflow,
   output logic [15:0]   drop_cnt,
   input  logic          clr_ovf
);

   localparam logic [AW:0] FULL_COUNT  = (AW+1)'(DEPTH);
   localparam logic [AW:0] AFULL_COUNT = (AW+1)'(AFULL_THRESH);
   localparam logic [15:0] DROP_MAX    = 16'hFFFF;

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count_q;
   logic [255:0]  mem [DEPTH];

   logic full;
   logic empty;
   logic pop;
   logic push;
   logic drop;

   // Handshake decode from registered occupancy; a pop frees the slot a
   // same-cycle write on a full buffer lands in.
   always_comb begin
      full  = (count_q == FULL_COUNT);
      empty = (count_q == '0);
      pop   = !empty && out_ready;
      push  = in_valid && (!full || pop);
      drop  = in_valid && full && !pop;
   end

   // Status and head-of-queue outputs, all decoded from registered state.
   always_comb begin
      count       = count_q;
      out_valid   = !empty;
      out_data    = mem[rd_ptr];
      almost_full = (count_q >= AFULL_COUNT);
   end

   // Storage: each entry is cleared on reset so out_data is never X.
   for (genvar i = 0; i < DEPTH; i++) begin : g_mem
      // Capture the incoming vector when this entry is the write target.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            mem[i] <= '0;
         end else if (push && (wr_ptr == AW'(i))) begin
            mem[i] <= in_data;
         end
      end
   end

   // Pointers wrap naturally at AW bits; occupancy tracks push/pop balance.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count_q <= count_q + 1'b1;
         end else if (pop && !push) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

   // Sticky overflow and saturating drop counter; a drop coinciding with a
   // clear restarts the count at one so the new event is not lost.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (clr_ovf) begin
            drop_cnt <= 16'd1;
         end else if (drop_cnt != DROP_MAX) begin
            drop_cnt <= drop_cnt + 16'd1;
         end
      end else if (clr_ovf) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ivb_vector_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ivb_vector_fifo                                           |
// | Description : Directed self-checking bench for ivb_vector_fifo.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ivb_vector_fifo;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         in_valid = 1'b0;
   logic [255:0] in_data = '0;
   logic         out_valid;
   logic [255:0] out_data;
   logic         out_ready = 1'b0;
   logic [3:0]   count;
   logic         almost_full;
   logic         overflow;
   logic [15:0]  drop_cnt;
   logic         clr_ovf = 1'b0;

   int errors = 0;
   int checks = 0;

   ivb_vector_fifo #(.DEPTH(8), .AW(3), .AFULL_THRESH(6)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .count(count), .almost_full(almost_full), .overflow(overflow),
      .drop_cnt(drop_cnt), .clr_ovf(clr_ovf)
   );

   always #5 clk = ~clk;

   // Inputs change just after a falling edge; the following falling edge
   // shows the state after the intervening rising edge.
   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic push_one(input logic [255:0] d);
      in_valid = 1'b1; in_data = d; cyc(); in_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; cyc(); cyc();
      checks++; if (count !== 4'd0) begin errors++; $display("FAIL rst_count got %0d want 0", count); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
      checks++; if (out_data !== 256'h0) begin errors++; $display("FAIL rst_out_data got %h want 0", out_data); end
      checks++; if (almost_full !== 1'b0 || overflow !== 1'b0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL rst_status got af=%b ovf=%b dc=%0d want 0 0 0", almost_full, overflow, drop_cnt); end
      reset = 1'b1; cyc();
   endtask

   task automatic test_fill3();
      out_ready = 1'b0;
      push_one(256'h1);
      checks++; if (out_valid !== 1'b1 || out_data !== 256'h1) begin errors++; $display("FAIL fwft_first got v=%b d=%h want 1 1", out_valid, out_data); end
      push_one(256'h2);
      push_one(256'h3);
      checks++; if (count !== 4'd3) begin errors++; $display("FAIL fill3_count got %0d want 3", count); end
      checks++; if (out_data !== 256'h1) begin errors++; $display("FAIL fill3_hold got %h want 1", out_data); end
   endtask

   task automatic test_drain3();
      out_ready = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         checks++; if (out_valid !== 1'b1 || out_data !== 256'(k)) begin errors++; $display("FAIL drain3_%0d got v=%b d=%h want 1 %0d", k, out_valid, out_data, k); end
         cyc();
      end
      out_ready = 1'b0;
      checks++; if (count !== 4'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL drain3_empty got c=%0d v=%b want 0 0", count, out_valid); end
   endtask

   task automatic test_overflow();
      out_ready = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         push_one(256'(k));
         checks++; if (almost_full !== (k >= 6)) begin errors++; $display("FAIL afull_at_%0d got %b want %b", k, almost_full, (k >= 6)); end
      end
      push_one(256'h9);
      checks++; if (overflow !== 1'b1 || drop_cnt !== 16'd1 || count !== 4'd8) begin errors++; $display("FAIL ovf_drop got ovf=%b dc=%0d c=%0d want 1 1 8", overflow, drop_cnt, count); end
      out_ready = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         checks++; if (out_valid !== 1'b1 || out_data !== 256'(k)) begin errors++; $display("FAIL ovf_drain_%0d got v=%b d=%h want 1 %0d", k, out_valid, out_data, k); end
         cyc();
      end
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL ovf_no_ninth got v=%b c=%0d want 0 0", out_valid, count); end
   endtask

   task automatic test_full_push_pop();
      out_ready = 1'b0;
      for (int k = 1; k <= 8; k++) push_one(256'h10 + 256'(k));
      in_valid = 1'b1; in_data = 256'h99; out_ready = 1'b1;
      cyc();
      in_valid = 1'b0; out_ready = 1'b0;
      checks++; if (count !== 4'd8 || out_data !== 256'h12) begin errors++; $display("FAIL fullpp_state got c=%0d d=%h want 8 12", count, out_data); end
      checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL fullpp_nodrop got dc=%0d want 1", drop_cnt); end
      out_ready = 1'b1;
      for (int k = 2; k <= 9; k++) begin
         logic [255:0] exp;
         exp = (k == 9) ? 256'h99 : 256'h10 + 256'(k);
         checks++; if (out_data !== exp) begin errors++; $display("FAIL fullpp_drain_%0d got %h want %h", k, out_data, exp); end
         cyc();
      end
      out_ready = 1'b0;
      checks++; if (count !== 4'd0) begin errors++; $display("FAIL fullpp_empty got %0d want 0", count); end
   endtask

   task automatic test_back_to_back();
      int bad_cnt;
      int bad_dat;
      bad_cnt = 0; bad_dat = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1; in_data = 256'h100 + 256'(i);
         if (i > 0 && (out_valid !== 1'b1 || out_data !== 256'h100 + 256'(i - 1))) bad_dat++;
         cyc();
         if (count !== 4'd1) bad_cnt++;
      end
      in_valid = 1'b0;
      checks++; if (bad_dat != 0) begin errors++; $display("FAIL wrap_order got %0d bad words want 0", bad_dat); end
      checks++; if (bad_cnt != 0) begin errors++; $display("FAIL wrap_count got %0d bad cycles want 0", bad_cnt); end
      checks++; if (out_data !== 256'h113) begin errors++; $display("FAIL wrap_last got %h want 113", out_data); end
      cyc();
      out_ready = 1'b0;
      checks++; if (count !== 4'd0) begin errors++; $display("FAIL wrap_empty got %0d want 0", count); end
   endtask

   task automatic test_clr();
      clr_ovf = 1'b1; cyc(); clr_ovf = 1'b0;
      checks++; if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL clr_alone got ovf=%b dc=%0d want 0 0", overflow, drop_cnt); end
      for (int k = 0; k < 8; k++) push_one(256'h200 + 256'(k));
      push_one(256'hdead);
      push_one(256'hbeef);
      checks++; if (drop_cnt !== 16'd2) begin errors++; $display("FAIL two_drops got %0d want 2", drop_cnt); end
      in_valid = 1'b1; clr_ovf = 1'b1; cyc(); in_valid = 1'b0; clr_ovf = 1'b0;
      checks++; if (overflow !== 1'b1 || drop_cnt !== 16'd1) begin errors++; $display("FAIL clr_with_drop got ovf=%b dc=%0d want 1 1", overflow, drop_cnt); end
   endtask

   task automatic test_saturate();
      in_valid = 1'b1;
      for (int k = 0; k < 65540; k++) cyc();
      in_valid = 1'b0;
      checks++; if (drop_cnt !== 16'hFFFF || overflow !== 1'b1) begin errors++; $display("FAIL drop_sat got dc=%h ovf=%b want ffff 1", drop_cnt, overflow); end
      checks++; if (count !== 4'd8 || out_data !== 256'h200) begin errors++; $display("FAIL drop_keep got c=%0d d=%h want 8 200", count, out_data); end
   endtask

   task automatic test_reset_mid();
      reset = 1'b0; cyc(); reset = 1'b1; cyc();
      for (int k = 0; k < 5; k++) push_one(256'h300 + 256'(k));
      checks++; if (count !== 4'd5) begin errors++; $display("FAIL pre_reset_count got %0d want 5", count); end
      #2 reset = 1'b0;
      #1;
      checks++; if (count !== 4'd0 || out_valid !== 1'b0 || out_data !== 256'h0) begin errors++; $display("FAIL async_reset got c=%0d v=%b d=%h want 0 0 0", count, out_valid, out_data); end
      cyc(); reset = 1'b1; cyc();
      push_one(256'hAA);
      checks++; if (count !== 4'd1 || out_data !== 256'hAA) begin errors++; $display("FAIL post_reset got c=%0d d=%h want 1 aa", count, out_data); end
   endtask

   initial begin
      test_reset();
      test_fill3();
      test_drain3();
      test_overflow();
      test_full_push_pop();
      test_back_to_back();
      test_clr();
      test_saturate();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
